// File: rtl/uart_tx_fifo_if.sv
// UART transmit handshake between the byte FIFO (master) and the UART transmitter (slave).
// The master drives a one-clk write pulse with data; the slave reports busy.
interface uart_tx_fifo_if;
  logic       uart_wr;
  logic [7:0] uart_data;
  logic       uart_busy;

  modport master (output uart_wr, output uart_data, input uart_busy);
  modport slave  (input uart_wr, input uart_data, output uart_busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO from the Z80 OUT decode to the UART transmitter, drained over the wr/busy handshake.
// Optional sticky overflow flag is compiled in with `define UART_TXF_OVERFLOW_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_WAIT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_data,
  uart_tx_fifo_if.master        uart,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TW-1:0]       TIMER_MAX  = TW'(BUSY_WAIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   countNext;
  logic [1:0]            state;
  logic [TW-1:0]         timer;
  logic                  wrQ;
  logic                  pushReq;
  logic                  doPush;
  logic                  doPop;

  // The strobe is a multi-cycle level; only its rising edge is a push.
  // full is the registered pre-pop value, so a push into a full FIFO drops even if a pop happens too.
  assign pushReq = cpu_wr & ~wrQ;
  assign doPush  = pushReq & ~full;
  assign doPop   = (state == IDLE) & ~empty & ~uart.uart_busy;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    countNext = count;
    if (doPush && !doPop)
      countNext = count + (DEPTH_LOG2 + 1)'(1);
    else if (!doPush && doPop)
      countNext = count - (DEPTH_LOG2 + 1)'(1);
  end

  // NOTE: storage is not reset; occupancy is tracked by pointers and count, so stale bytes are never read.
  always_ff @(posedge clk) begin
    if (doPush)
      mem[wrPtr] <= cpu_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrQ            <= 1'b0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      state          <= IDLE;
      timer          <= '0;
      uart.uart_wr   <= 1'b0;
      uart.uart_data <= 8'h00;
    end else begin
      wrQ   <= cpu_wr;
      count <= countNext;
      full  <= (countNext == FULL_COUNT);
      empty <= (countNext == '0);
      if (doPush)
        wrPtr <= wrPtr + DEPTH_LOG2'(1);

      uart.uart_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (doPop) begin
            uart.uart_data <= mem[rdPtr];
            uart.uart_wr   <= 1'b1;
            rdPtr          <= rdPtr + DEPTH_LOG2'(1);
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          // A UART that finishes before busy is seen must not stall the drain.
          if (uart.uart_busy)
            state <= WAIT_LO;
          else if (timer == TIMER_MAX)
            state <= IDLE;
          else
            timer <= timer + TW'(1);
        end
        WAIT_LO: begin
          if (!uart.uart_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXF_OVERFLOW_EN
  // Set has priority over a simultaneous clear so no dropped byte goes unreported.
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (pushReq && full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end
`else
  logic unusedOvfClr;
  assign unusedOvfClr = ovf_clr;
  assign overflow     = 1'b0;
`endif

endmodule
